// File: rtl/trdb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trdb_pkg: E-Trace itype codes and instruction MASK/MATCH patterns.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package trdb_pkg;

    localparam logic [3:0] ITYPE_NONE            = 4'd0;
    localparam logic [3:0] ITYPE_EXCEPTION       = 4'd1;
    localparam logic [3:0] ITYPE_INTERRUPT       = 4'd2;
    localparam logic [3:0] ITYPE_EXC_RETURN      = 4'd3;
    localparam logic [3:0] ITYPE_NOT_TAKEN       = 4'd4;
    localparam logic [3:0] ITYPE_TAKEN           = 4'd5;
    localparam logic [3:0] ITYPE_UNINF_JUMP      = 4'd6;
    localparam logic [3:0] ITYPE_RESERVED        = 4'd7;
    localparam logic [3:0] ITYPE_UNINF_CALL      = 4'd8;
    localparam logic [3:0] ITYPE_INF_CALL        = 4'd9;
    localparam logic [3:0] ITYPE_UNINF_TAIL      = 4'd10;
    localparam logic [3:0] ITYPE_INF_TAIL        = 4'd11;
    localparam logic [3:0] ITYPE_CO_SWAP         = 4'd12;
    localparam logic [3:0] ITYPE_RETURN          = 4'd13;
    localparam logic [3:0] ITYPE_OTHER_UNINF_JUMP = 4'd14;
    localparam logic [3:0] ITYPE_OTHER_INF_JUMP  = 4'd15;

    // Opcode-only match covers BEQ..BGEU and the PULP P.BEQIMM/P.BNEIMM slots.
    localparam logic [31:0] MASK_BRANCH   = 32'h0000_007f;
    localparam logic [31:0] MATCH_BRANCH  = 32'h0000_0063;
    localparam logic [31:0] MASK_C_BRANCH = 32'h0000_e003;
    localparam logic [31:0] MATCH_C_BEQZ  = 32'h0000_c001;
    localparam logic [31:0] MATCH_C_BNEZ  = 32'h0000_e001;
    localparam logic [31:0] MASK_JALR     = 32'h0000_707f;
    localparam logic [31:0] MATCH_JALR    = 32'h0000_0067;
    localparam logic [31:0] MASK_JAL      = 32'h0000_007f;
    localparam logic [31:0] MATCH_JAL     = 32'h0000_006f;
    localparam logic [31:0] MASK_MRET     = 32'hffff_ffff;
    localparam logic [31:0] MATCH_MRET    = 32'h3020_0073;
    localparam logic [31:0] MASK_SRET     = 32'hffff_ffff;
    localparam logic [31:0] MATCH_SRET    = 32'h1020_0073;

    function automatic logic is_link_reg(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/trdb_itype_lane_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trdb_itype_lane_classifier: combinational itype of one retired instruction.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trdb_itype_lane_classifier
    import trdb_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ITYPE_LEN = 3
) (
    input  logic [XLEN-1:0]      addr_i,
    input  logic [XLEN-1:0]      insn_i,
    input  logic                 compressed_i,
    input  logic [XLEN-1:0]      next_i,
    input  logic                 has_next_i,
    input  logic                 trap_i,
    input  logic                 irq_i,
    output logic [ITYPE_LEN-1:0] itype_o
);

    logic [31:0]     insn32;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic            rd_link;
    logic            rs1_link;
    logic            is_eret;
    logic            is_jalr;
    logic            is_jal;
    logic            is_branch;
    logic [XLEN-1:0] seq_addr;

    assign insn32    = insn_i[31:0];
    assign rd        = insn32[11:7];
    assign rs1       = insn32[19:15];
    assign rd_link   = is_link_reg(rd);
    assign rs1_link  = is_link_reg(rs1);
    assign is_eret   = !compressed_i && (((insn32 & MASK_MRET) == MATCH_MRET) ||
                                         ((insn32 & MASK_SRET) == MATCH_SRET));
    assign is_jalr   = !compressed_i && ((insn32 & MASK_JALR) == MATCH_JALR);
    assign is_jal    = !compressed_i && ((insn32 & MASK_JAL) == MATCH_JAL);
    assign is_branch = compressed_i ? (((insn32 & MASK_C_BRANCH) == MATCH_C_BEQZ) ||
                                       ((insn32 & MASK_C_BRANCH) == MATCH_C_BNEZ))
                                    : ((insn32 & MASK_BRANCH) == MATCH_BRANCH);
    assign seq_addr  = addr_i + (compressed_i ? XLEN'(2) : XLEN'(4));

    always_comb begin
        itype_o = ITYPE_LEN'(ITYPE_NONE);
        if (trap_i) begin
            itype_o = irq_i ? ITYPE_LEN'(ITYPE_INTERRUPT) : ITYPE_LEN'(ITYPE_EXCEPTION);
        end else if (is_eret) begin
            itype_o = ITYPE_LEN'(ITYPE_EXC_RETURN);
        end else if (is_jalr) begin
            if (ITYPE_LEN == 3)                              itype_o = ITYPE_LEN'(ITYPE_UNINF_JUMP);
            else if (rd_link && rs1_link && (rd != rs1))     itype_o = ITYPE_LEN'(ITYPE_CO_SWAP);
            else if (rd_link)                                itype_o = ITYPE_LEN'(ITYPE_UNINF_CALL);
            else if (rs1_link && (rd == 5'd0))               itype_o = ITYPE_LEN'(ITYPE_RETURN);
            else if (rd == 5'd0)                             itype_o = ITYPE_LEN'(ITYPE_UNINF_TAIL);
            else                                             itype_o = ITYPE_LEN'(ITYPE_OTHER_UNINF_JUMP);
        end else if (is_jal) begin
            if (ITYPE_LEN == 3)        itype_o = ITYPE_LEN'(ITYPE_NONE);
            else if (rd_link)          itype_o = ITYPE_LEN'(ITYPE_INF_CALL);
            else if (rd == 5'd0)       itype_o = ITYPE_LEN'(ITYPE_INF_TAIL);
            else                       itype_o = ITYPE_LEN'(ITYPE_OTHER_INF_JUMP);
        end else if (is_branch && has_next_i) begin
            itype_o = (next_i != seq_addr) ? ITYPE_LEN'(ITYPE_TAKEN) : ITYPE_LEN'(ITYPE_NOT_TAKEN);
        end
    end

endmodule
`default_nettype wire

// File: rtl/trdb_itype_classifier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trdb_itype_classifier: multi-retirement itype classifier, youngest pending.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module trdb_itype_classifier
    import trdb_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int NRET      = 2,
    parameter  int ITYPE_LEN = 3,
    localparam int NOUT      = NRET + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [NRET-1:0]           valid_i,
    input  logic [NRET*XLEN-1:0]      iaddr_i,
    input  logic [NRET*XLEN-1:0]      insn_i,
    input  logic [NRET-1:0]           compressed_i,
    input  logic                      exception_i,
    input  logic                      interrupt_i,
    output logic [NOUT-1:0]           valid_o,
    output logic [NOUT*XLEN-1:0]      iaddr_o,
    output logic [NOUT*ITYPE_LEN-1:0] itype_o
);

    localparam int CW = $clog2(NOUT + 1);

    logic                             pend_v_q, pend_v_d;
    logic [XLEN-1:0]                  pend_addr_q, pend_addr_d;
    logic [XLEN-1:0]                  pend_insn_q, pend_insn_d;
    logic                             pend_c_q, pend_c_d;

    logic [NOUT-1:0]                  valid_q, valid_d;
    logic [NOUT-1:0][XLEN-1:0]        iaddr_q, iaddr_d;
    logic [NOUT-1:0][ITYPE_LEN-1:0]   itype_q, itype_d;

    logic [CW-1:0]                    lane_cnt;
    logic [CW-1:0]                    elem_cnt;
    logic                             lane_run;

    logic [NOUT-1:0][XLEN-1:0]        e_addr;
    logic [NOUT-1:0][XLEN-1:0]        e_insn;
    logic [NOUT-1:0]                  e_c;
    logic [NOUT-1:0][XLEN-1:0]        next_addr;
    logic [NOUT-1:0]                  has_next;
    logic [NOUT-1:0]                  is_trap;
    logic [NOUT-1:0]                  emit;
    logic [NOUT-1:0][ITYPE_LEN-1:0]   lane_itype;

    // Only the contiguous run of valid lanes starting at lane 0 counts.
    always_comb begin
        lane_cnt = '0;
        lane_run = 1'b1;
        for (int i = 0; i < NRET; i++) begin
            if (lane_run && valid_i[i]) lane_cnt = lane_cnt + CW'(1);
            else                        lane_run = 1'b0;
        end
        elem_cnt = lane_cnt + CW'(pend_v_q);
    end

    for (genvar k = 0; k < NOUT; k++) begin : g_elem
        // With a pending instruction the retired lanes shift up by one slot.
        if (k == 0) begin : g_first
            assign e_addr[k] = pend_v_q ? pend_addr_q : iaddr_i[XLEN-1:0];
            assign e_insn[k] = pend_v_q ? pend_insn_q : insn_i[XLEN-1:0];
            assign e_c[k]    = pend_v_q ? pend_c_q    : compressed_i[0];
        end else if (k < NRET) begin : g_mid
            assign e_addr[k] = pend_v_q ? iaddr_i[(k-1)*XLEN +: XLEN] : iaddr_i[k*XLEN +: XLEN];
            assign e_insn[k] = pend_v_q ? insn_i[(k-1)*XLEN +: XLEN]  : insn_i[k*XLEN +: XLEN];
            assign e_c[k]    = pend_v_q ? compressed_i[k-1]           : compressed_i[k];
        end else begin : g_top
            assign e_addr[k] = iaddr_i[(k-1)*XLEN +: XLEN];
            assign e_insn[k] = insn_i[(k-1)*XLEN +: XLEN];
            assign e_c[k]    = compressed_i[k-1];
        end

        if (k < NOUT - 1) begin : g_succ
            assign next_addr[k] = e_addr[k+1];
        end else begin : g_no_succ
            assign next_addr[k] = '0;
        end

        assign has_next[k] = CW'(k + 1) < elem_cnt;
        assign is_trap[k]  = exception_i && (CW'(k + 1) == elem_cnt);
        assign emit[k]     = has_next[k] || is_trap[k];

        trdb_itype_lane_classifier #(
            .XLEN      (XLEN),
            .ITYPE_LEN (ITYPE_LEN)
        ) u_lane (
            .addr_i       (e_addr[k]),
            .insn_i       (e_insn[k]),
            .compressed_i (e_c[k]),
            .next_i       (next_addr[k]),
            .has_next_i   (has_next[k]),
            .trap_i       (is_trap[k]),
            .irq_i        (interrupt_i),
            .itype_o      (lane_itype[k])
        );
    end

    always_comb begin
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        pend_insn_d = pend_insn_q;
        pend_c_d    = pend_c_q;
        if (exception_i) begin
            pend_v_d    = 1'b0;
            pend_addr_d = '0;
            pend_insn_d = '0;
            pend_c_d    = 1'b0;
        end else begin
            for (int i = 0; i < NRET; i++) begin
                if (lane_cnt == CW'(i + 1)) begin
                    pend_v_d    = 1'b1;
                    pend_addr_d = iaddr_i[i*XLEN +: XLEN];
                    pend_insn_d = insn_i[i*XLEN +: XLEN];
                    pend_c_d    = compressed_i[i];
                end
            end
        end
    end

    always_comb begin
        valid_d = emit;
        iaddr_d = iaddr_q;
        itype_d = itype_q;
        for (int k = 0; k < NOUT; k++) begin
            if (emit[k]) begin
                iaddr_d[k] = e_addr[k];
                itype_d[k] = lane_itype[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pend_v_q    <= 1'b0;
            pend_addr_q <= '0;
            pend_insn_q <= '0;
            pend_c_q    <= 1'b0;
            valid_q     <= '0;
            iaddr_q     <= '0;
            itype_q     <= '0;
        end else begin
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            pend_insn_q <= pend_insn_d;
            pend_c_q    <= pend_c_d;
            valid_q     <= valid_d;
            iaddr_q     <= iaddr_d;
            itype_q     <= itype_d;
        end
    end

    assign valid_o = valid_q;
    assign iaddr_o = iaddr_q;
    assign itype_o = itype_q;

endmodule
`default_nettype wire

// File: tb/tb_trdb_itype_classifier.sv
`default_nettype none
// Bench for trdb_itype_classifier: 3-bit and 4-bit instances share one stimulus
// stream; a stream-level reference model predicts every output each cycle.
`timescale 1ns/1ps
module tb_trdb_itype_classifier;

    localparam int XLEN = 32;
    localparam int NRET = 2;
    localparam int NOUT = NRET + 1;

    localparam logic [31:0] ADD_I    = 32'h0031_00b3;
    localparam logic [31:0] BEQ_I    = 32'h0000_0063;
    localparam logic [31:0] BNE_I    = 32'h0000_1063;
    localparam logic [31:0] CBEQZ_I  = 32'h0000_c001;
    localparam logic [31:0] JALR01_I = 32'h0000_8067;   // jalr x0, 0(x1)
    localparam logic [31:0] JALR16_I = 32'h0003_00e7;   // jalr x1, 0(x6)
    localparam logic [31:0] JAL0_I   = 32'h0000_006f;   // jal x0, 0
    localparam logic [31:0] MRET_I   = 32'h3020_0073;
    localparam logic [31:0] SRET_I   = 32'h1020_0073;

    logic                   clk = 1'b0;
    logic                   rst_ni = 1'b0;
    logic [NRET-1:0]        valid_i = '0;
    logic [NRET*XLEN-1:0]   iaddr_i = '0;
    logic [NRET*XLEN-1:0]   insn_i = '0;
    logic [NRET-1:0]        compressed_i = '0;
    logic                   exception_i = 1'b0;
    logic                   interrupt_i = 1'b0;

    logic [NOUT-1:0]        valid3, valid4;
    logic [NOUT*XLEN-1:0]   iaddr3, iaddr4;
    logic [NOUT*3-1:0]      itype3;
    logic [NOUT*4-1:0]      itype4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    trdb_itype_classifier #(.XLEN(XLEN), .NRET(NRET), .ITYPE_LEN(3)) dut3 (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .iaddr_i(iaddr_i),
        .insn_i(insn_i), .compressed_i(compressed_i), .exception_i(exception_i),
        .interrupt_i(interrupt_i), .valid_o(valid3), .iaddr_o(iaddr3), .itype_o(itype3)
    );

    trdb_itype_classifier #(.XLEN(XLEN), .NRET(NRET), .ITYPE_LEN(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_ni), .valid_i(valid_i), .iaddr_i(iaddr_i),
        .insn_i(insn_i), .compressed_i(compressed_i), .exception_i(exception_i),
        .interrupt_i(interrupt_i), .valid_o(valid4), .iaddr_o(iaddr4), .itype_o(itype4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] insn;
        logic        c;
    } elem_t;

    function automatic int classify(input elem_t e, input logic [31:0] next, input int ilen);
        logic [4:0] rd;
        logic [4:0] rs1;
        bit rdl, rsl;
        rd  = e.insn[11:7];
        rs1 = e.insn[19:15];
        rdl = (rd == 5'd1) || (rd == 5'd5);
        rsl = (rs1 == 5'd1) || (rs1 == 5'd5);
        if (e.c) begin
            if (e.insn[1:0] == 2'b01 && e.insn[15:14] == 2'b11)
                return (next != 32'(e.addr + 32'd2)) ? 5 : 4;
            return 0;
        end
        if (e.insn == MRET_I || e.insn == SRET_I) return 3;
        if (e.insn[6:0] == 7'b1100111 && e.insn[14:12] == 3'b000) begin
            if (ilen == 3) return 6;
            if (rdl && rsl && rd != rs1) return 12;
            if (rdl) return 8;
            if (rsl && rd == 5'd0) return 13;
            if (rd == 5'd0) return 10;
            return 14;
        end
        if (e.insn[6:0] == 7'b1101111) begin
            if (ilen == 3) return 0;
            if (rdl) return 9;
            if (rd == 5'd0) return 11;
            return 15;
        end
        if (e.insn[6:0] == 7'b1100011) return (next != 32'(e.addr + 32'd4)) ? 5 : 4;
        return 0;
    endfunction

    elem_t           m_pend;
    bit              m_pv;
    elem_t           s[$];
    elem_t           tmp;
    logic [NOUT-1:0] exp_valid;
    logic [31:0]     exp_addr [NOUT];
    int              exp_it3  [NOUT];
    int              exp_it4  [NOUT];

    always @(posedge clk) begin
        if (!rst_ni) begin
            m_pv      = 1'b0;
            exp_valid = '0;
            for (int k = 0; k < NOUT; k++) begin
                exp_addr[k] = '0;
                exp_it3[k]  = 0;
                exp_it4[k]  = 0;
            end
        end else begin
            s.delete();
            if (m_pv) s.push_back(m_pend);
            for (int i = 0; i < NRET; i++) begin
                if (!valid_i[i]) break;
                tmp.addr = iaddr_i[i*XLEN +: XLEN];
                tmp.insn = insn_i[i*XLEN +: XLEN];
                tmp.c    = compressed_i[i];
                s.push_back(tmp);
            end
            exp_valid = '0;
            for (int k = 0; k < s.size(); k++) begin
                if (k + 1 < s.size()) begin
                    exp_valid[k] = 1'b1;
                    exp_addr[k]  = s[k].addr;
                    exp_it3[k]   = classify(s[k], s[k+1].addr, 3);
                    exp_it4[k]   = classify(s[k], s[k+1].addr, 4);
                end else if (exception_i) begin
                    exp_valid[k] = 1'b1;
                    exp_addr[k]  = s[k].addr;
                    exp_it3[k]   = interrupt_i ? 2 : 1;
                    exp_it4[k]   = interrupt_i ? 2 : 1;
                end
            end
            if (exception_i) m_pv = 1'b0;
            else if (s.size() > 0) begin
                m_pv   = 1'b1;
                m_pend = s[s.size()-1];
            end
        end
    end

    always @(negedge clk) begin
        check("valid3", 32'(valid3), 32'(exp_valid));
        check("valid4", 32'(valid4), 32'(exp_valid));
        for (int k = 0; k < NOUT; k++) begin
            check($sformatf("iaddr3[%0d]", k), iaddr3[k*XLEN +: XLEN], exp_addr[k]);
            check($sformatf("iaddr4[%0d]", k), iaddr4[k*XLEN +: XLEN], exp_addr[k]);
            check($sformatf("itype3[%0d]", k), 32'(itype3[k*3 +: 3]), 32'(exp_it3[k]));
            check($sformatf("itype4[%0d]", k), 32'(itype4[k*4 +: 4]), 32'(exp_it4[k]));
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [31:0] a3(input int k);
        return iaddr3[k*XLEN +: XLEN];
    endfunction
    function automatic logic [31:0] t3(input int k);
        return 32'(itype3[k*3 +: 3]);
    endfunction
    function automatic logic [31:0] t4(input int k);
        return 32'(itype4[k*4 +: 4]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        valid_i      = '0;
        exception_i  = 1'b0;
        interrupt_i  = 1'b0;
        compressed_i = '0;
    endtask

    task automatic set_lane(input int i, input logic [31:0] a, input logic [31:0] ins, input logic c);
        iaddr_i[i*XLEN +: XLEN] = a;
        insn_i[i*XLEN +: XLEN]  = ins;
        compressed_i[i]         = c;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 4))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            3:       return 5'd6;
            default: return 5'($urandom);
        endcase
    endfunction

    task automatic gen_insn(output logic [31:0] ins, output logic c);
        logic [31:0] r;
        r   = $urandom;
        ins = r;
        c   = 1'b0;
        case ($urandom_range(0, 9))
            0, 1: ins[6:0] = 7'h63;
            2: begin c = 1'b1; ins = {16'h0, 2'b11, r[13:2], 2'b01}; end
            3: begin c = 1'b1; ins = {16'h0, 3'b000, r[12:2], 2'b01}; end
            4, 5: begin
                ins[6:0]   = 7'h67;
                ins[14:12] = 3'b000;
                ins[11:7]  = pick_reg();
                ins[19:15] = pick_reg();
            end
            6: begin ins[6:0] = 7'h6f; ins[11:7] = pick_reg(); end
            7: ins = r[0] ? MRET_I : SRET_I;
            default: ins[6:0] = 7'h33;
        endcase
    endtask

    logic [31:0] pc;

    task automatic rand_cycle();
        logic [31:0] ins;
        logic        c;
        rst_ni = ($urandom_range(0, 99) != 0);
        case ($urandom_range(0, 4))
            0:       valid_i = 2'b00;
            1:       valid_i = 2'b01;
            2:       valid_i = 2'b10;
            default: valid_i = 2'b11;
        endcase
        for (int i = 0; i < NRET; i++) begin
            gen_insn(ins, c);
            if ($urandom_range(0, 5) == 0)
                pc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : (32'($urandom) & ~32'h1);
            set_lane(i, pc, ins, c);
            pc = pc + (c ? 32'd2 : 32'd4);
        end
        exception_i = ($urandom_range(0, 9) == 0);
        interrupt_i = 1'($urandom_range(0, 1));
        tick();
    endtask

    initial begin
        idle();
        rst_ni  = 1'b0;
        valid_i = 2'b11;
        set_lane(0, 32'h50, ADD_I, 1'b0);
        set_lane(1, 32'h54, ADD_I, 1'b0);
        tick();
        check("reset_valid3_c1", 32'(valid3), 32'h0);
        tick();
        check("reset_valid4_c2", 32'(valid4), 32'h0);

        rst_ni = 1'b1;
        idle(); valid_i = 2'b01; set_lane(0, 32'h80, ADD_I, 1'b0);
        tick();
        check("first_only_pending", 32'(valid3), 32'h0);

        idle(); exception_i = 1'b1;
        tick();
        check("flush_valid", 32'(valid3), 32'h1);
        check("flush_itype", t3(0), 32'd1);
        check("flush_addr", a3(0), 32'h80);

        idle(); valid_i = 2'b11;
        set_lane(0, 32'h100, BEQ_I, 1'b0); set_lane(1, 32'h104, ADD_I, 1'b0);
        tick();
        check("beq_nt_valid", 32'(valid3), 32'h1);
        check("beq_nt_addr", a3(0), 32'h100);
        check("beq_nt_itype", t3(0), 32'd4);

        idle(); valid_i = 2'b11; exception_i = 1'b1;
        set_lane(0, 32'h108, ADD_I, 1'b0); set_lane(1, 32'h10C, ADD_I, 1'b0);
        tick();
        check("trap_valid", 32'(valid3), 32'h7);
        check("trap_addr0", a3(0), 32'h104);
        check("trap_it1", t3(1), 32'd0);
        check("trap_it2", t3(2), 32'd1);
        check("trap_addr2", a3(2), 32'h10C);

        idle(); exception_i = 1'b1;
        tick();
        check("trap_empty", 32'(valid3), 32'h0);

        idle(); valid_i = 2'b01; set_lane(0, 32'h110, ADD_I, 1'b0);
        tick();
        idle(); valid_i = 2'b01; exception_i = 1'b1; interrupt_i = 1'b1;
        set_lane(0, 32'h114, ADD_I, 1'b0);
        tick();
        check("irq_valid", 32'(valid4), 32'h3);
        check("irq_itype", t4(1), 32'd2);

        idle(); valid_i = 2'b01; set_lane(0, 32'h200, BNE_I, 1'b0);
        tick();
        idle();
        tick(); tick(); tick();
        check("idle_hold", 32'(valid3), 32'h0);
        valid_i = 2'b01; set_lane(0, 32'h240, ADD_I, 1'b0);
        tick();
        check("bne_taken_valid", 32'(valid3), 32'h1);
        check("bne_taken_itype", t3(0), 32'd5);

        idle(); valid_i = 2'b11;
        set_lane(0, 32'h200, CBEQZ_I, 1'b1); set_lane(1, 32'h202, ADD_I, 1'b0);
        tick();
        check("cbeqz_nt_itype", t3(1), 32'd4);
        check("cbeqz_nt_addr", a3(1), 32'h200);

        idle(); valid_i = 2'b11;
        set_lane(0, 32'h300, JALR01_I, 1'b0); set_lane(1, 32'h500, ADD_I, 1'b0);
        tick();
        check("jalr_ret_it3", t3(1), 32'd6);
        check("jalr_ret_it4", t4(1), 32'd13);

        idle(); valid_i = 2'b11;
        set_lane(0, 32'h600, JALR16_I, 1'b0); set_lane(1, 32'h604, JAL0_I, 1'b0);
        tick();
        check("jalr_call_it4", t4(1), 32'd8);

        idle(); valid_i = 2'b01; set_lane(0, 32'h700, ADD_I, 1'b0);
        tick();
        check("jal_x0_it3", t3(0), 32'd0);
        check("jal_x0_it4", t4(0), 32'd11);

        idle(); valid_i = 2'b10; set_lane(1, 32'h800, ADD_I, 1'b0);
        tick();
        check("noncontig", 32'(valid3), 32'h0);

        idle(); valid_i = 2'b11;
        set_lane(0, 32'h400, MRET_I, 1'b0); set_lane(1, 32'h1000, ADD_I, 1'b0);
        tick();
        check("pend_kept_addr", a3(0), 32'h700);
        check("mret_itype", t3(1), 32'd3);

        idle(); rst_ni = 1'b0;
        tick();
        rst_ni = 1'b1; exception_i = 1'b1;
        tick();
        check("reset_discards", 32'(valid3), 32'h0);

        pc = 32'h2000;
        repeat (3000) rand_cycle();
        idle(); rst_ni = 1'b1;
        tick();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
`default_nettype wire
